seg595_scan_ctrl: RTL and testbench
===================================

// Module: seg595_scan_ctrl
// PURPOSE
//   Multiplexed scan controller for an N-digit 7-segment display driven through two cascaded 74HC595s.
//   Each digit slot: selects one BCD nibble, decodes it via an internal decode_bcd instance, and serialises
//   a 16-bit word {dig_sel, seg} onto DS/SHCP. It then pulses STCP and holds for the scan period.
//   Sits between the application's BCD value registers and the 595 pins.
// PARAMETERS
//   NUM_DIGITS   8      digit positions scanned, 1..8
//   CLK_DIV      4      clk cycles per SHCP/STCP half-period, >=1
//   SCAN_CYCLES  50000  clk cycles per digit slot; must be >= 34*CLK_DIV+2 (elaboration $error otherwise)
// PORTS
//   clk         in   1             system clock
//   rst_n       in   1             asynchronous active-low reset
//   en          in   1             scan enable
//   bcd_in      in   4*NUM_DIGITS  digit i value = bcd_in[4i+3:4i]
//   dp_en       in   NUM_DIGITS    1 = light decimal point of digit i
//   ds          out  1             595 serial data
//   shcp        out  1             595 shift clock
//   stcp        out  1             595 storage/latch clock
//   oe_n        out  1             595 output enable, active low
//   busy        out  1             1 while a digit slot is in progress
//   frame_done  out  1             1-cycle pulse when the last digit slot ends
// BEHAVIOUR
//   Reset (async, rst_n=0): ds=0, shcp=0, stcp=0, oe_n=1, busy=0, frame_done=0, digit index=0, FSM=IDLE.
//   All outputs are registered; no combinational path from inputs to pins.
//   Word format:
//     seg = decode_bcd(nibble); bit0 is DP, active low, forced 0 when dp_en[i]=1.
//     Nibbles >9 give the decoder dash 8'hFD.
//     dig_sel = 8'b1 << i (one-hot, active high).
//     word = {dig_sel, seg}, shifted MSB first: dig_sel lands in the far 595, seg in the near 595.
//   FSM:
//     IDLE  -> LOAD when en=1.
//     LOAD  1 cycle: capture word for digit i into shift reg; start slot counter (0); busy=1.
//     SHIFT 16 bits. Each bit: ds updated on entry with shcp=0, CLK_DIV cycles low, then CLK_DIV cycles high.
//           Total 32*CLK_DIV cycles; shcp returns to 0 at the end.
//     LATCH stcp=1 for CLK_DIV cycles, then 0 for CLK_DIV cycles. oe_n<=0 on the first completed latch.
//     HOLD  wait until slot counter = SCAN_CYCLES-1, so each slot is exactly SCAN_CYCLES cycles from LOAD.
//           Then:
//           - Advance i; wrap NUM_DIGITS-1 -> 0 and pulse frame_done in the same cycle.
//           - en=1 -> LOAD.
//           - en=0 -> IDLE with busy=0, oe_n=1, i=0.
//   en deassert mid-slot: the slot completes fully, including latch and hold. Never truncate a shift.
//   bcd_in/dp_en changes after LOAD do not affect the current word; they take effect at the next LOAD.
//   Re-enable after IDLE always starts at digit 0.
//   rst_n mid-shift: immediate reset. The partial word is never latched (stcp stays 0).
// TESTING (NUM_DIGITS=4, CLK_DIV=2, SCAN_CYCLES=100; bench models the 595 pair)
//   1. Reset asserted at arbitrary time -> ds/shcp/stcp/busy/frame_done=0 and oe_n=1 within the same cycle.
//   2. bcd_in=16'h4321, dp_en=0, en=1 -> latched words 16'h019F, 16'h0225, 16'h040D, 16'h0899 in order.
//      STCP rising edges exactly 100 cycles apart; frame_done once per 400 cycles.
//   3. bcd_in=16'h3A00, dp_en=4'b1000 -> digit2 word 16'h04FD; digit3 word 16'h080C.
//   4. en dropped during the 5th bit of digit1 -> digit1 word latched intact, then IDLE with oe_n=1.
//      Re-enable -> first word is digit0.
//   5. bcd_in changed mid-shift -> current latched word equals the value present at LOAD.
//   6. rst_n pulsed mid-shift, then en=1 -> no stcp pulse before the new slot.
//      First latched word is digit0; oe_n goes low only after that latch.

Source files
------------

// File: rtl/seg595_scan_ctrl_if.sv
// Pin bundle for a cascaded pair of 74HC595 shift registers.
// The controller drives it as master; a board model or pad ring takes the slave side.
interface seg595_scan_ctrl_if;
    logic ds;
    logic shcp;
    logic stcp;
    logic oe_n;

    modport master (
        output ds,
        output shcp,
        output stcp,
        output oe_n
    );

    modport slave (
        input ds,
        input shcp,
        input stcp,
        input oe_n
    );
endinterface

// File: rtl/seg595_scan_ctrl.sv
// Multiplexed 7-segment scan controller feeding two cascaded 74HC595s.
// Each slot serialises {dig_sel, seg} MSB first, latches it, then holds.
module decode_bcd (
    input  logic [3:0] bcd,
    output logic [7:0] seg
);
    // Active low, {a,b,c,d,e,f,g,dp}; dp left dark here.
    always_comb begin
        seg = 8'hFD;
        unique case (bcd)
            4'd0:    seg = 8'h03;
            4'd1:    seg = 8'h9F;
            4'd2:    seg = 8'h25;
            4'd3:    seg = 8'h0D;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h49;
            4'd6:    seg = 8'h41;
            4'd7:    seg = 8'h1F;
            4'd8:    seg = 8'h01;
            4'd9:    seg = 8'h09;
            default: seg = 8'hFD;
        endcase
    end
endmodule

module seg595_scan_ctrl #(
    parameter int NUM_DIGITS  = 8,
    parameter int CLK_DIV     = 4,
    parameter int SCAN_CYCLES = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_en,
    seg595_scan_ctrl_if.master      pins,
    output logic                    busy,
    output logic                    frame_done
);
    localparam int CW = $clog2(SCAN_CYCLES);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [2:0]    IDX_LAST = 3'(NUM_DIGITS - 1);

    generate
        if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
            $error("NUM_DIGITS must be 1..8");
        end
        if (CLK_DIV < 1) begin : g_bad_div
            $error("CLK_DIV must be >= 1");
        end
        if (SCAN_CYCLES < 34 * CLK_DIV + 2) begin : g_bad_scan
            $error("SCAN_CYCLES must be >= 34*CLK_DIV+2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        LATCH,
        HOLD
    } state_t;

    state_t        state;
    logic [2:0]    idx;
    logic [CW-1:0] cnt;
    logic [DW-1:0] div;
    logic          hi;
    logic [3:0]    bitn;
    logic [15:0]   sreg;
    logic          ds_q;
    logic          shcp_q;
    logic          stcp_q;
    logic          oe_n_q;

    logic [3:0]    nib;
    logic          dp;
    logic [7:0]    seg_raw;
    logic [7:0]    seg;
    logic [7:0]    dig_sel;
    logic [15:0]   word;

    always_comb begin
        nib = 4'd0;
        dp  = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == 3'(k)) begin
                nib = bcd_in[4*k +: 4];
                dp  = dp_en[k];
            end
        end
    end

    decode_bcd u_dec (
        .bcd (nib),
        .seg (seg_raw)
    );

    assign seg     = {seg_raw[7:1], seg_raw[0] & ~dp};
    assign dig_sel = 8'b1 << idx;
    assign word    = {dig_sel, seg};

    // Slot counter runs from 0 in LOAD so every slot spans SCAN_CYCLES.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 3'd0;
            cnt        <= '0;
            div        <= '0;
            hi         <= 1'b0;
            bitn       <= 4'd0;
            sreg       <= 16'd0;
            ds_q       <= 1'b0;
            shcp_q     <= 1'b0;
            stcp_q     <= 1'b0;
            oe_n_q     <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (state != IDLE) begin
                cnt <= cnt + 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (en) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                LOAD: begin
                    sreg   <= word;
                    ds_q   <= word[15];
                    shcp_q <= 1'b0;
                    div    <= '0;
                    hi     <= 1'b0;
                    bitn   <= 4'd0;
                    state  <= SHIFT;
                end
                SHIFT: begin
                    if (div == DIV_LAST) begin
                        div <= '0;
                        if (!hi) begin
                            hi     <= 1'b1;
                            shcp_q <= 1'b1;
                        end else begin
                            hi     <= 1'b0;
                            shcp_q <= 1'b0;
                            if (bitn == 4'd15) begin
                                state  <= LATCH;
                                stcp_q <= 1'b1;
                            end else begin
                                bitn <= bitn + 4'd1;
                                sreg <= {sreg[14:0], 1'b0};
                                ds_q <= sreg[14];
                            end
                        end
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                LATCH: begin
                    if (div == DIV_LAST) begin
                        div <= '0;
                        if (stcp_q) begin
                            stcp_q <= 1'b0;
                            oe_n_q <= 1'b0;
                        end else begin
                            state <= HOLD;
                        end
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == CNT_LAST) begin
                        if (idx == IDX_LAST) begin
                            idx        <= 3'd0;
                            frame_done <= 1'b1;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                        if (en) begin
                            state <= LOAD;
                            cnt   <= '0;
                        end else begin
                            state  <= IDLE;
                            busy   <= 1'b0;
                            oe_n_q <= 1'b1;
                            idx    <= 3'd0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pins.ds   = ds_q;
    assign pins.shcp = shcp_q;
    assign pins.stcp = stcp_q;
    assign pins.oe_n = oe_n_q;
endmodule

// File: tb/tb_seg595_scan_ctrl.sv
// Bench for seg595_scan_ctrl with a behavioural 595 pair on the pins.
// Checks latched words, slot/frame timing, en drop, mid-shift change and reset.
module tb_seg595_scan_ctrl;
    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] bcd_in;
    logic [3:0]  dp_en;
    logic        busy;
    logic        frame_done;

    seg595_scan_ctrl_if pins ();

    seg595_scan_ctrl #(
        .NUM_DIGITS  (4),
        .CLK_DIV     (2),
        .SCAN_CYCLES (100)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .bcd_in     (bcd_in),
        .dp_en      (dp_en),
        .pins       (pins),
        .busy       (busy),
        .frame_done (frame_done)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int sh_cnt = 0;
    int base;
    int nlat;

    logic [15:0] sr = 16'd0;
    logic [15:0] lat_q[$];
    int          stcp_t[$];
    int          fd_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge pins.shcp) begin
        sr = {sr[14:0], pins.ds};
        sh_cnt++;
    end

    always @(posedge pins.stcp) begin
        lat_q.push_back(sr);
        stcp_t.push_back(cyc);
    end

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_q.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_lat(input int n, input int budget);
        int t = 0;
        while (lat_q.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (lat_q.size() < n) check("lat_timeout", lat_q.size(), n);
    endtask

    task automatic wait_sh(input int n, input int budget);
        int t = 0;
        while (sh_cnt < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (sh_cnt < n) check("shcp_timeout", sh_cnt, n);
    endtask

    task automatic wait_fd(input int n, input int budget);
        int t = 0;
        while (fd_q.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (fd_q.size() < n) check("fd_timeout", fd_q.size(), n);
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while (busy !== 1'b0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (busy !== 1'b0) check("idle_timeout", busy, 0);
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b0;
        bcd_in = 16'h0000;
        dp_en  = 4'b0000;
        repeat (3) @(negedge clk);
        check("rst_pins", {pins.ds, pins.shcp, pins.stcp, pins.oe_n,
                           busy, frame_done}, 6'b000100);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_rst", {busy, pins.oe_n, pins.stcp}, 3'b010);

        // Plain scan of 4321
        bcd_in = 16'h4321;
        en     = 1'b1;
        wait_lat(1, 200);
        check("oe_before_first", pins.oe_n, 1'b1);
        repeat (4) @(negedge clk);
        check("oe_after_first", pins.oe_n, 1'b0);
        check("busy_run", busy, 1'b1);
        wait_lat(4, 500);
        check("w_d0", lat_q[0], 16'h019F);
        check("w_d1", lat_q[1], 16'h0225);
        check("w_d2", lat_q[2], 16'h040D);
        check("w_d3", lat_q[3], 16'h0899);
        check("stcp_gap1", stcp_t[1] - stcp_t[0], 100);
        check("stcp_gap2", stcp_t[2] - stcp_t[1], 100);
        check("stcp_gap3", stcp_t[3] - stcp_t[2], 100);
        wait_fd(2, 1000);
        check("fd_gap", fd_q[1] - fd_q[0], 400);
        check("w_f2_d0", lat_q[4], 16'h019F);
        check("w_f2_d3", lat_q[7], 16'h0899);
        en = 1'b0;
        wait_idle(300);
        check("idle_oe", pins.oe_n, 1'b1);

        // Dash and decimal point
        lat_q.delete();
        stcp_t.delete();
        bcd_in = 16'h3A00;
        dp_en  = 4'b1000;
        en     = 1'b1;
        wait_lat(4, 500);
        check("dp_d0", lat_q[0], 16'h0103);
        check("dp_d1", lat_q[1], 16'h0203);
        check("dash_d2", lat_q[2], 16'h04FD);
        check("dp_d3", lat_q[3], 16'h080C);

        // Drop en during bit 5 of digit1
        wait_lat(5, 200);
        base = sh_cnt;
        wait_sh(base + 4, 200);
        repeat (2) @(negedge clk);
        en = 1'b0;
        wait_lat(6, 200);
        check("drop_d1", lat_q[5], 16'h0203);
        wait_idle(200);
        check("drop_idle", {busy, pins.oe_n}, 2'b01);
        repeat (150) @(negedge clk);
        check("drop_no_more", lat_q.size(), 6);

        // Re-enable starts at digit0
        lat_q.delete();
        bcd_in = 16'h4321;
        dp_en  = 4'b0000;
        en     = 1'b1;
        wait_lat(1, 200);
        check("reen_d0", lat_q[0], 16'h019F);

        // bcd change mid-shift only affects the next LOAD
        base = sh_cnt;
        wait_sh(base + 3, 200);
        bcd_in = 16'h9999;
        wait_lat(2, 200);
        check("mid_d1", lat_q[1], 16'h0225);
        wait_lat(3, 200);
        check("next_d2", lat_q[2], 16'h0409);

        // Reset mid-shift of digit3
        base = sh_cnt;
        wait_sh(base + 6, 200);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid", {pins.ds, pins.shcp, pins.stcp, pins.oe_n,
                          busy, frame_done}, 6'b000100);
        nlat = lat_q.size();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_no_latch", lat_q.size(), nlat);
        wait_lat(nlat + 1, 200);
        check("rst_first_d0", lat_q[nlat], 16'h0109);
        check("rst_oe_held", pins.oe_n, 1'b1);
        repeat (4) @(negedge clk);
        check("rst_oe_low", pins.oe_n, 1'b0);

        en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
